shared_mem_bank_arbiter: RTL

Parametrised shared-memory bank arbiter. Accepts one warp-wide request: per-lane word addresses, active-lane mask and read/write mode. Serialises bank conflicts into the minimum number of grant beats toward the bank array and crossbar. Adds two things the earlier arbiter lacked: same-address read broadcast and same-address write collapse. Also provides a valid/ready handshake on both sides and a conflict statistics counter.

---
 rtl/shared_mem_pkg.sv | 27 ++
 rtl/shared_mem_bank_picker.sv | 63 ++++++
 rtl/shared_mem_bank_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared types, derived widths and address split helpers for the bank arbiter
package shared_mem_pkg;

  typedef enum logic [0:0] {IDLE, ISSUE} arb_state_t;

  function automatic int calc_bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int calc_row_w(input int addr_width, input int num_banks);
    return addr_width - calc_bank_w(num_banks);
  endfunction

  function automatic int calc_lane_w(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  // Low address bits select the bank, the remaining upper bits are the row.
  function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int bank_w);
    return addr & ((32'd1 << bank_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_row(input logic [31:0] addr, input int bank_w);
    return addr >> bank_w;
  endfunction

endpackage

// File: rtl/shared_mem_bank_picker.sv
// rtl/shared_mem_bank_picker.sv - per-bank leader/group selection over the pending lanes
module shared_mem_bank_picker
  import shared_mem_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int NUM_BANKS  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int BANK_IDX   = 0,
  localparam int BANK_W    = calc_bank_w(NUM_BANKS),
  localparam int ROW_W     = calc_row_w(ADDR_WIDTH, NUM_BANKS),
  localparam int LANE_W    = calc_lane_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0]            i_pending,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] i_addr,
  input  logic                            i_write,
  output logic                            o_en,
  output logic [ROW_W-1:0]                o_row,
  output logic [LANE_W-1:0]               o_lane,
  output logic [NUM_LANES-1:0]            o_group
);

  logic [31:0]          w_a;
  logic [NUM_LANES-1:0] w_hit;
  logic [ROW_W-1:0]     w_row [NUM_LANES];
  logic                 w_found;
  logic [LANE_W-1:0]    w_lead;
  logic [LANE_W-1:0]    w_last;
  logic [ROW_W-1:0]     w_lead_row;

  always_comb begin
    w_a        = '0;
    w_hit      = '0;
    w_found    = 1'b0;
    w_lead     = '0;
    w_last     = '0;
    w_lead_row = '0;
    o_group    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_a      = 32'(i_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      w_hit[i] = i_pending[i] && (addr_bank(w_a, BANK_W) == 32'(BANK_IDX));
      w_row[i] = ROW_W'(addr_row(w_a, BANK_W));
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_hit[i] && !w_found) begin
        w_found    = 1'b1;
        w_lead     = LANE_W'(i);
        w_lead_row = w_row[i];
      end
    end
    // Highest matching lane is kept so a collapsed store takes the last writer's data.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_hit[i] && (w_row[i] == w_lead_row)) begin
        o_group[i] = 1'b1;
        w_last     = LANE_W'(i);
      end
    end
  end

  assign o_en   = w_found;
  assign o_row  = w_lead_row;
  assign o_lane = i_write ? w_last : w_lead;

endmodule

// File: rtl/shared_mem_bank_arbiter.sv
// rtl/shared_mem_bank_arbiter.sv - warp request serialiser with read broadcast and write collapse
module shared_mem_bank_arbiter
  import shared_mem_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int NUM_BANKS  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16,
  localparam int ROW_W     = calc_row_w(ADDR_WIDTH, NUM_BANKS),
  localparam int LANE_W    = calc_lane_w(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_LANES-1:0]            req_mask,
  input  logic                            req_write,
  output logic                            grant_valid,
  input  logic                            grant_ready,
  output logic [NUM_LANES-1:0]            grant_lanes,
  output logic                            grant_last,
  output logic [NUM_BANKS-1:0]            bank_en,
  output logic [NUM_BANKS*ROW_W-1:0]      bank_row,
  output logic [NUM_BANKS*LANE_W-1:0]     bank_lane,
  input  logic                            stat_clear,
  output logic [CNT_WIDTH-1:0]            conflict_cnt
);

  arb_state_t                      r_state;
  arb_state_t                      w_next;
  logic [NUM_LANES*ADDR_WIDTH-1:0] r_addr;
  logic                            r_write;
  logic [NUM_LANES-1:0]            r_pending;
  logic                            r_first;
  logic [CNT_WIDTH-1:0]            r_cnt;
  logic [NUM_LANES-1:0]            w_group [NUM_BANKS];
  logic [NUM_LANES-1:0]            w_grant;
  logic                            w_xfer;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    shared_mem_bank_picker #(
      .NUM_LANES (NUM_LANES),
      .NUM_BANKS (NUM_BANKS),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BANK_IDX  (b)
    ) u_picker (
      .i_pending(r_pending),
      .i_addr   (r_addr),
      .i_write  (r_write),
      .o_en     (bank_en[b]),
      .o_row    (bank_row[b*ROW_W +: ROW_W]),
      .o_lane   (bank_lane[b*LANE_W +: LANE_W]),
      .o_group  (w_group[b])
    );
  end

  always_comb begin
    w_grant = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_grant = w_grant | w_group[b];
    end
  end

  // Pending is empty in IDLE, so all per-bank outputs already read zero there.
  assign grant_lanes  = w_grant;
  assign grant_last   = (r_state == ISSUE) && ((r_pending & ~w_grant) == '0);
  assign w_xfer       = grant_valid && grant_ready;
  assign conflict_cnt = r_cnt;

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    grant_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ISSUE;
      end
      ISSUE: begin
        grant_valid = 1'b1;
        if (grant_ready && grant_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_pending <= '0;
      r_first   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (req_valid && req_ready) begin
        r_addr    <= req_addr;
        r_write   <= req_write;
        r_pending <= req_mask;
        r_first   <= 1'b1;
      end else if (w_xfer) begin
        r_pending <= r_pending & ~w_grant;
        r_first   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (stat_clear) begin
      r_cnt <= '0;
    end else if (w_xfer && !r_first && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
